// File: rtl/uart_xcvr_param_if.sv
// User-side handshake bundle for uart_xcvr_param: TX word input and RX FIFO read port.
// The DUT binds to the slave modport; user logic or the bench drives the master side.
interface uart_xcvr_param_if #(
    parameter int DATA_BITS = 8,
    parameter int RX_DEPTH  = 4
);
    localparam int COUNT_W = $clog2(RX_DEPTH) + 1;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_perr;
    logic                 rx_ferr;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_overrun;
    logic [COUNT_W-1:0]   rx_count;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_perr, rx_ferr, rx_valid, rx_overrun, rx_count
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_perr, rx_ferr, rx_valid, rx_overrun, rx_count
    );
endinterface

// File: rtl/uart_xcvr_param.sv
// Parametrised full-duplex UART: handshaked transmitter plus receiver feeding a small
// FIFO that stores each word with its parity and framing error flags.
module uart_xcvr_param #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int RX_DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_xcvr_param_if.slave      bus,
    output logic                  tx,
    input  logic                  rx
);
    localparam int   CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int   BIT_W   = 3;
    localparam int   HALF    = CLKS_PER_BIT / 2;
    localparam int   PTR_W   = $clog2(RX_DEPTH);
    localparam int   COUNT_W = PTR_W + 1;
    localparam logic HAS_PAR = (PARITY != 0);
    localparam logic ODD     = (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- transmitter ----------------
    state_t               tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;
    logic                 tx_tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_tick    = (tx_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
        if (tx_state_q != S_IDLE) tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
        case (tx_state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (bus.tx_valid) begin
                    tx_shift_d = bus.tx_data;
                    tx_par_d   = (^bus.tx_data) ^ ODD;
                    tx_cnt_d   = '0;
                    tx_d       = 1'b0;
                    tx_state_d = S_START;
                end
            end
            S_START: if (tx_tick) begin
                tx_bit_d   = '0;
                tx_d       = tx_shift_q[0];
                tx_state_d = S_DATA;
            end
            S_DATA: if (tx_tick) begin
                tx_shift_d = tx_shift_q >> 1;
                if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
                    tx_bit_d   = '0;
                    tx_d       = HAS_PAR ? tx_par_q : 1'b1;
                    tx_state_d = HAS_PAR ? S_PARITY : S_STOP;
                end else begin
                    tx_bit_d = tx_bit_q + 1'b1;
                    tx_d     = tx_shift_d[0];
                end
            end
            S_PARITY: if (tx_tick) begin
                tx_d       = 1'b1;
                tx_state_d = S_STOP;
            end
            S_STOP: if (tx_tick) begin
                if (tx_bit_q == BIT_W'(STOP_BITS - 1)) tx_state_d = S_IDLE;
                else tx_bit_d = tx_bit_q + 1'b1;
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    assign tx           = tx_q;
    assign bus.tx_ready = (tx_state_q == S_IDLE);

    // ---------------- receiver ----------------
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    state_t               rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
    logic                 rx_brk_q, rx_brk_d, rx_wr_q, rx_wr_d;
    logic                 rx_tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_brk_q   <= 1'b0;
            rx_wr_q    <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_brk_q   <= rx_brk_d;
            rx_wr_q    <= rx_wr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_brk_d   = rx_brk_q;
        rx_wr_d    = 1'b0;
        rx_tick    = (rx_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = S_START;
            end
            S_START: if (rx_cnt_q == CNT_W'(HALF - 1)) begin
                rx_cnt_d = '0;
                if (!rx_sync_q) begin
                    rx_bit_d   = '0;
                    rx_perr_d  = 1'b0;
                    rx_ferr_d  = 1'b0;
                    rx_state_d = S_DATA;
                end else begin
                    rx_state_d = S_IDLE;
                end
            end
            S_DATA: if (rx_tick) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                if (rx_bit_q == BIT_W'(DATA_BITS - 1)) rx_state_d = HAS_PAR ? S_PARITY : S_STOP;
                else rx_bit_d = rx_bit_q + 1'b1;
            end
            S_PARITY: if (rx_tick) begin
                rx_cnt_d   = '0;
                rx_perr_d  = rx_sync_q ^ (^rx_shift_q) ^ ODD;
                rx_state_d = S_STOP;
            end
            S_STOP: begin
                // After a framing error, hold here until the line idles so a break cannot retrigger.
                if (rx_brk_q) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_brk_d   = 1'b0;
                        rx_state_d = S_IDLE;
                    end
                end else if (rx_tick) begin
                    rx_cnt_d  = '0;
                    rx_ferr_d = !rx_sync_q;
                    rx_wr_d   = 1'b1;
                    if (rx_sync_q) rx_state_d = S_IDLE;
                    else rx_brk_d = 1'b1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS+1:0] mem [RX_DEPTH];
    logic [DATA_BITS+1:0] head;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [COUNT_W-1:0]   count_q;
    logic                 ovr_q, full, not_empty, pop, push;

    assign full      = (count_q == COUNT_W'(RX_DEPTH));
    assign not_empty = (count_q != '0);
    assign pop       = not_empty && bus.rx_ready;
    assign push      = rx_wr_q && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + COUNT_W'(push) - COUNT_W'(pop);
            ovr_q   <= rx_wr_q && full && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {rx_ferr_q, rx_perr_q, rx_shift_q};
    end

    assign head           = mem[rd_ptr_q];
    assign bus.rx_data    = not_empty ? head[DATA_BITS-1:0] : '0;
    assign bus.rx_perr    = not_empty ? head[DATA_BITS] : 1'b0;
    assign bus.rx_ferr    = not_empty ? head[DATA_BITS+1] : 1'b0;
    assign bus.rx_valid   = not_empty;
    assign bus.rx_overrun = ovr_q;
    assign bus.rx_count   = count_q;
endmodule
